// File: rtl/cmd_timing_scheduler_pkg.sv
// Shared definitions for the command timing scheduler.
//
// Holds the SoftMC field offsets (each overridable from a softMC.inc that is
// compiled earlier), the command-class encoding, the decode function that
// turns the CS/RAS/CAS/WE bits into a class, and the default DDR4 timing
// values used as parameter defaults by cmd_timing_scheduler.

`ifndef CS_OFFSET
`define CS_OFFSET 27
`endif
`ifndef RAS_OFFSET
`define RAS_OFFSET 26
`endif
`ifndef CAS_OFFSET
`define CAS_OFFSET 25
`endif
`ifndef WE_OFFSET
`define WE_OFFSET 24
`endif
`ifndef ROW_OFFSET
`define ROW_OFFSET 18
`endif

package cmd_timing_scheduler_pkg;

  typedef enum logic [2:0] {
    CMD_NOP   = 3'd0,
    CMD_ACT   = 3'd1,
    CMD_RD    = 3'd2,
    CMD_WR    = 3'd3,
    CMD_PRE   = 3'd4,
    CMD_REF   = 3'd5,
    CMD_DESEL = 3'd6,
    CMD_OTHER = 3'd7   // MRS/ZQ and similar: passed through ungated
  } cmd_class_e;

  localparam int DEF_BANK_WIDTH = 3;
  localparam int DEF_CNT_WIDTH  = 8;
  localparam int DEF_T_RCD      = 4;
  localparam int DEF_T_RP       = 4;
  localparam int DEF_T_RAS      = 10;
  localparam int DEF_T_RRD      = 2;
  localparam int DEF_T_CCD      = 2;
  localparam int DEF_T_WTR      = 4;
  localparam int DEF_T_RFC      = 30;

  // All command strobes are active low.
  function automatic cmd_class_e decode_cmd(input logic cs_n, input logic ras_n,
                                            input logic cas_n, input logic we_n);
    cmd_class_e cls;
    if (cs_n) begin
      cls = CMD_DESEL;
    end else begin
      case ({ras_n, cas_n, we_n})
        3'b011:  cls = CMD_ACT;
        3'b101:  cls = CMD_RD;
        3'b100:  cls = CMD_WR;
        3'b010:  cls = CMD_PRE;
        3'b001:  cls = CMD_REF;
        3'b111:  cls = CMD_NOP;
        default: cls = CMD_OTHER;
      endcase
    end
    return cls;
  endfunction

endpackage

// File: rtl/cmd_timing_scheduler_if.sv
// Instruction path between host FIFO, scheduler and decoder.
//
// Signals: in_valid/in_instr/in_ready (host -> scheduler handshake),
// dec_en/dec_instr (scheduler -> decoder), bank_open (per-bank row status),
// proto_err (illegal command dropped).
// Modports: slave = scheduler side, master = host/decoder side.

interface cmd_timing_scheduler_if #(
  parameter int BANK_WIDTH = 3
);
  logic                       in_valid;
  logic [31:0]                in_instr;
  logic                       in_ready;
  logic                       dec_en;
  logic [31:0]                dec_instr;
  logic [(2**BANK_WIDTH)-1:0] bank_open;
  logic                       proto_err;

  modport slave (
    input  in_valid, in_instr,
    output in_ready, dec_en, dec_instr, bank_open, proto_err
  );

  modport master (
    output in_valid, in_instr,
    input  in_ready, dec_en, dec_instr, bank_open, proto_err
  );
endinterface

// File: rtl/cmd_timing_scheduler_down_counter.sv
// sched_down_counter: loadable saturating down-counter with zero flag.
//
// Ports: clk, rst_n (sync, active low), load_i/load_val_i (load wins over
// decrement), zero_o (count is zero). Decrements once per cycle while
// nonzero and sticks at zero.

module sched_down_counter #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load_i,
  input  logic [WIDTH-1:0] load_val_i,
  output logic             zero_o
);

  logic [WIDTH-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = load_val_i;
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/cmd_timing_scheduler.sv
// cmd_timing_scheduler: holds one SoftMC instruction at a time and releases
// it to the decoder once every DDR4 timing counter that gates it has expired.
// Protocol-illegal commands are dropped and flagged on proto_err.
//
// Ports:
//   clk, rst_n          controller clock, synchronous active-low reset
//   bus (slave)         in_valid/in_instr/in_ready, dec_en/dec_instr,
//                       bank_open, proto_err
//   stall_cycles        only when CMD_SCHED_STATS_EN is defined: saturating
//                       count of cycles a held instruction waited on timing
//
// Optional feature macro: CMD_SCHED_STATS_EN
//
// state   | meaning
// --------+-----------------------------------------------------------
// IDLE    | holding register empty, in_ready high
// HOLD    | instruction held, waiting for its counters (or being dropped)

module cmd_timing_scheduler
  import cmd_timing_scheduler_pkg::*;
#(
  parameter int BANK_WIDTH = DEF_BANK_WIDTH,
  parameter int CNT_WIDTH  = DEF_CNT_WIDTH,
  parameter int T_RCD      = DEF_T_RCD,
  parameter int T_RP       = DEF_T_RP,
  parameter int T_RAS      = DEF_T_RAS,
  parameter int T_RRD      = DEF_T_RRD,
  parameter int T_CCD      = DEF_T_CCD,
  parameter int T_WTR      = DEF_T_WTR,
  parameter int T_RFC      = DEF_T_RFC
) (
  input  logic                  clk,
  input  logic                  rst_n,
  cmd_timing_scheduler_if.slave bus
`ifdef CMD_SCHED_STATS_EN
  ,
  output logic [31:0]           stall_cycles
`endif
);

  localparam int NUM_BANKS = 2 ** BANK_WIDTH;

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_HOLD = 1'b1;

  localparam logic [CNT_WIDTH-1:0] LD_RCD = CNT_WIDTH'(T_RCD - 1);
  localparam logic [CNT_WIDTH-1:0] LD_RP  = CNT_WIDTH'(T_RP - 1);
  localparam logic [CNT_WIDTH-1:0] LD_RAS = CNT_WIDTH'(T_RAS - 1);
  localparam logic [CNT_WIDTH-1:0] LD_RRD = CNT_WIDTH'(T_RRD - 1);
  localparam logic [CNT_WIDTH-1:0] LD_CCD = CNT_WIDTH'(T_CCD - 1);
  localparam logic [CNT_WIDTH-1:0] LD_WTR = CNT_WIDTH'(T_WTR - 1);
  localparam logic [CNT_WIDTH-1:0] LD_RFC = CNT_WIDTH'(T_RFC - 1);

  logic [0:0]           state_q, state_d;
  logic [31:0]          hold_instr_q, hold_instr_d;
  logic [NUM_BANKS-1:0] bank_open_q, bank_open_d;
  logic                 dec_en_q;
  logic [31:0]          dec_instr_q;
  logic                 proto_err_q;

  logic                  hold_valid;
  logic                  in_ready;
  logic                  accept;
  cmd_class_e            cls;
  logic [BANK_WIDTH-1:0] bank;
  logic                  gate_ok;
  logic                  legal;
  logic                  issue_now;
  logic                  drop;

  logic iss_act, iss_pre, iss_rd, iss_wr, iss_ref;

  logic [NUM_BANKS-1:0] rcd_zero, ras_zero, rp_zero;
  logic                 rrd_zero, ccd_zero, wtr_zero, rfc_zero;

  assign hold_valid = (state_q == ST_HOLD);
  assign cls  = decode_cmd(hold_instr_q[`CS_OFFSET], hold_instr_q[`RAS_OFFSET],
                           hold_instr_q[`CAS_OFFSET], hold_instr_q[`WE_OFFSET]);
  assign bank = hold_instr_q[`ROW_OFFSET +: BANK_WIDTH];

  // Legality depends only on bank_open, which cannot change while an
  // instruction is held, so an illegal command is dropped straight away
  // rather than waiting for its timing counters.
  always_comb begin
    gate_ok = 1'b1;
    legal   = 1'b1;
    case (cls)
      CMD_ACT: begin
        gate_ok = rp_zero[bank] && rrd_zero && rfc_zero;
        legal   = !bank_open_q[bank];
      end
      CMD_RD: begin
        gate_ok = rcd_zero[bank] && ccd_zero && wtr_zero && rfc_zero;
        legal   = bank_open_q[bank];
      end
      CMD_WR: begin
        gate_ok = rcd_zero[bank] && ccd_zero && rfc_zero;
        legal   = bank_open_q[bank];
      end
      CMD_PRE: begin
        gate_ok = ras_zero[bank] && rfc_zero;
      end
      CMD_REF: begin
        gate_ok = (&rp_zero) && rfc_zero;
        legal   = (bank_open_q == '0);
      end
      default: ;
    endcase
  end

  assign issue_now = hold_valid && legal && gate_ok;
  assign drop      = hold_valid && !legal;
  assign in_ready  = !hold_valid || issue_now;
  assign accept    = bus.in_valid && in_ready;

  assign iss_act = issue_now && (cls == CMD_ACT);
  assign iss_pre = issue_now && (cls == CMD_PRE);
  assign iss_rd  = issue_now && (cls == CMD_RD);
  assign iss_wr  = issue_now && (cls == CMD_WR);
  assign iss_ref = issue_now && (cls == CMD_REF);

  for (genvar gi = 0; gi < NUM_BANKS; gi++) begin : g_bank
    logic sel;
    assign sel = (bank == BANK_WIDTH'(gi));

    sched_down_counter #(.WIDTH(CNT_WIDTH)) u_rcd (
      .clk(clk), .rst_n(rst_n), .load_i(iss_act && sel),
      .load_val_i(LD_RCD), .zero_o(rcd_zero[gi])
    );
    sched_down_counter #(.WIDTH(CNT_WIDTH)) u_ras (
      .clk(clk), .rst_n(rst_n), .load_i(iss_act && sel),
      .load_val_i(LD_RAS), .zero_o(ras_zero[gi])
    );
    sched_down_counter #(.WIDTH(CNT_WIDTH)) u_rp (
      .clk(clk), .rst_n(rst_n), .load_i(iss_pre && sel),
      .load_val_i(LD_RP), .zero_o(rp_zero[gi])
    );
  end

  sched_down_counter #(.WIDTH(CNT_WIDTH)) u_rrd (
    .clk(clk), .rst_n(rst_n), .load_i(iss_act),
    .load_val_i(LD_RRD), .zero_o(rrd_zero)
  );
  sched_down_counter #(.WIDTH(CNT_WIDTH)) u_ccd (
    .clk(clk), .rst_n(rst_n), .load_i(iss_rd || iss_wr),
    .load_val_i(LD_CCD), .zero_o(ccd_zero)
  );
  sched_down_counter #(.WIDTH(CNT_WIDTH)) u_wtr (
    .clk(clk), .rst_n(rst_n), .load_i(iss_wr),
    .load_val_i(LD_WTR), .zero_o(wtr_zero)
  );
  sched_down_counter #(.WIDTH(CNT_WIDTH)) u_rfc (
    .clk(clk), .rst_n(rst_n), .load_i(iss_ref),
    .load_val_i(LD_RFC), .zero_o(rfc_zero)
  );

  always_comb begin
    state_d      = state_q;
    hold_instr_d = hold_instr_q;
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          state_d      = ST_HOLD;
          hold_instr_d = bus.in_instr;
        end
      end
      ST_HOLD: begin
        if (issue_now || drop) begin
          if (accept) begin
            hold_instr_d = bus.in_instr;
          end else begin
            state_d = ST_IDLE;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // PRE to an already-closed bank just clears a bit that is already clear.
  always_comb begin
    bank_open_d = bank_open_q;
    if (iss_act) bank_open_d[bank] = 1'b1;
    if (iss_pre) bank_open_d[bank] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      hold_instr_q <= '0;
      bank_open_q  <= '0;
      dec_en_q     <= 1'b0;
      dec_instr_q  <= '0;
      proto_err_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      hold_instr_q <= hold_instr_d;
      bank_open_q  <= bank_open_d;
      dec_en_q     <= issue_now;
      proto_err_q  <= drop;
      if (issue_now) dec_instr_q <= hold_instr_q;
    end
  end

`ifdef CMD_SCHED_STATS_EN
  logic [31:0] stall_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      stall_q <= '0;
    end else if (hold_valid && !issue_now && (stall_q != 32'hFFFF_FFFF)) begin
      stall_q <= stall_q + 32'd1;
    end
  end

  assign stall_cycles = stall_q;
`endif

  assign bus.in_ready  = in_ready;
  assign bus.dec_en    = dec_en_q;
  assign bus.dec_instr = dec_instr_q;
  assign bus.bank_open = bank_open_q;
  assign bus.proto_err = proto_err_q;

endmodule

// File: tb/tb_cmd_timing_scheduler.sv
// Directed testbench for cmd_timing_scheduler. A negedge monitor logs every
// dec_en and proto_err pulse with its cycle number; each test task drives a
// short instruction sequence and compares logged spacing against
// hand-computed DDR4 timing values.

module tb_cmd_timing_scheduler;

  localparam int BW     = 3;
  localparam int CS_B   = 27;
  localparam int RAS_B  = 26;
  localparam int CAS_B  = 25;
  localparam int WE_B   = 24;
  localparam int BANK_B = 18;

  // {cs_n, ras_n, cas_n, we_n}
  localparam logic [3:0] C_ACT = 4'b0011;
  localparam logic [3:0] C_RD  = 4'b0101;
  localparam logic [3:0] C_WR  = 4'b0100;
  localparam logic [3:0] C_PRE = 4'b0010;
  localparam logic [3:0] C_REF = 4'b0001;
  localparam logic [3:0] C_NOP = 4'b0111;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  cmd_timing_scheduler_if #(.BANK_WIDTH(BW)) bus ();

`ifdef CMD_SCHED_STATS_EN
  logic [31:0] stall_cycles;
`endif

  cmd_timing_scheduler #(.BANK_WIDTH(BW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
`ifdef CMD_SCHED_STATS_EN
    ,
    .stall_cycles (stall_cycles)
`endif
  );

  int n_checks = 0;
  int n_fail   = 0;

  int          cyc = 0;
  int          ev_cyc[$];
  logic [31:0] ev_ins[$];
  logic [7:0]  ev_bo[$];
  int          pe_cyc[$];
  logic        pe_rdy[$];

  always @(posedge clk) cyc++;

  always @(negedge clk) begin
    if (bus.dec_en === 1'b1) begin
      ev_cyc.push_back(cyc);
      ev_ins.push_back(bus.dec_instr);
      ev_bo.push_back(bus.bank_open);
    end
    if (bus.proto_err === 1'b1) begin
      pe_cyc.push_back(cyc);
      pe_rdy.push_back(bus.in_ready);
    end
  end

  function automatic int ec(input int i);
    return (i < ev_cyc.size()) ? ev_cyc[i] : -1000;
  endfunction

  function automatic logic [31:0] ei(input int i);
    return (i < ev_ins.size()) ? ev_ins[i] : 32'hxxxx_xxxx;
  endfunction

  function automatic logic [7:0] ebo(input int i);
    return (i < ev_bo.size()) ? ev_bo[i] : 8'hxx;
  endfunction

  function automatic logic [31:0] mk(input logic [3:0] c, input int b, input logic [7:0] tag);
    logic [31:0] w;
    logic [BW-1:0] bb;
    w = 32'h0;
    bb = b[BW-1:0];
    w[CS_B]  = c[3];
    w[RAS_B] = c[2];
    w[CAS_B] = c[1];
    w[WE_B]  = c[0];
    w[BANK_B +: BW] = bb;
    w[7:0] = tag;
    return w;
  endfunction

  task automatic clr();
    ev_cyc.delete();
    ev_ins.delete();
    ev_bo.delete();
    pe_cyc.delete();
    pe_rdy.delete();
  endtask

  task automatic do_reset();
    bus.in_valid = 1'b0;
    bus.in_instr = '0;
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    clr();
  endtask

  // Called at a negedge; returns at the negedge after the accepting edge.
  task automatic send(input logic [31:0] ins, output int acc);
    int k;
    k = 0;
    bus.in_valid = 1'b1;
    bus.in_instr = ins;
    while (bus.in_ready !== 1'b1 && k < 200) begin
      @(negedge clk);
      k++;
    end
    if (k >= 200) begin
      n_fail++;
      $display("FAIL send_timeout: in_ready never high for instr %h", ins);
    end
    acc = cyc;
    @(negedge clk);
    bus.in_valid = 1'b0;
    bus.in_instr = '0;
  endtask

  task automatic wait_ev(input int n, input int budget);
    int k;
    k = 0;
    while (ev_cyc.size() < n && k < budget) begin
      @(negedge clk);
      k++;
    end
    if (ev_cyc.size() < n) begin
      n_fail++;
      $display("FAIL wait_dec_en: got %0d dec_en pulses, need %0d", ev_cyc.size(), n);
    end
  endtask

  task automatic test_reset();
    int a;
    do_reset();
    send(mk(C_ACT, 0, 8'h01), a);
    wait_ev(1, 20);
    rst_n = 1'b0;
    @(negedge clk);
    n_checks++;
    if (bus.in_ready !== 1'b1) begin
      n_fail++; $display("FAIL reset_in_ready: got %b want 1", bus.in_ready);
    end
    n_checks++;
    if (bus.dec_en !== 1'b0) begin
      n_fail++; $display("FAIL reset_dec_en: got %b want 0", bus.dec_en);
    end
    n_checks++;
    if (bus.dec_instr !== 32'h0) begin
      n_fail++; $display("FAIL reset_dec_instr: got %h want 0", bus.dec_instr);
    end
    n_checks++;
    if (bus.proto_err !== 1'b0) begin
      n_fail++; $display("FAIL reset_proto_err: got %b want 0", bus.proto_err);
    end
    n_checks++;
    if (bus.bank_open !== 8'h00) begin
      n_fail++; $display("FAIL reset_bank_open: got %h want 00", bus.bank_open);
    end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_act_rd();
    int a0, a1;
    do_reset();
    send(mk(C_ACT, 0, 8'h11), a0);
    send(mk(C_RD, 0, 8'h12), a1);
    wait_ev(2, 50);
    n_checks++;
    if (ec(0) - a0 !== 2) begin
      n_fail++; $display("FAIL act_latency: got %0d want 2", ec(0) - a0);
    end
    n_checks++;
    if (ei(0) !== mk(C_ACT, 0, 8'h11)) begin
      n_fail++; $display("FAIL act_instr: got %h want %h", ei(0), mk(C_ACT, 0, 8'h11));
    end
    n_checks++;
    if (ei(1) !== mk(C_RD, 0, 8'h12)) begin
      n_fail++; $display("FAIL rd_instr: got %h want %h", ei(1), mk(C_RD, 0, 8'h12));
    end
    n_checks++;
    if (ec(1) - ec(0) !== 4) begin
      n_fail++; $display("FAIL act_rd_trcd: got %0d want 4", ec(1) - ec(0));
    end
    n_checks++;
    if (ebo(0) !== 8'h01) begin
      n_fail++; $display("FAIL act_bank_open: got %h want 01", ebo(0));
    end
  endtask

  task automatic test_act_pre_act();
    int a;
    logic [7:0] b0, b1, b2;
    do_reset();
    send(mk(C_ACT, 1, 8'h21), a);
    send(mk(C_PRE, 1, 8'h22), a);
    send(mk(C_ACT, 1, 8'h23), a);
    wait_ev(3, 80);
    n_checks++;
    if (ec(1) - ec(0) !== 10) begin
      n_fail++; $display("FAIL act_pre_tras: got %0d want 10", ec(1) - ec(0));
    end
    n_checks++;
    if (ec(2) - ec(1) !== 4) begin
      n_fail++; $display("FAIL pre_act_trp: got %0d want 4", ec(2) - ec(1));
    end
    b0 = ebo(0);
    b1 = ebo(1);
    b2 = ebo(2);
    n_checks++;
    if ({b0[1], b1[1], b2[1]} !== 3'b101) begin
      n_fail++; $display("FAIL bank1_toggle: got %b%b%b want 101", b0[1], b1[1], b2[1]);
    end
  endtask

  task automatic test_wtr();
    int a;
    do_reset();
    send(mk(C_ACT, 2, 8'h31), a);
    send(mk(C_WR, 2, 8'h32), a);
    send(mk(C_RD, 2, 8'h33), a);
    wait_ev(3, 60);
    n_checks++;
    if (ec(1) - ec(0) !== 4) begin
      n_fail++; $display("FAIL act_wr_trcd: got %0d want 4", ec(1) - ec(0));
    end
    n_checks++;
    if (ec(2) - ec(1) !== 4) begin
      n_fail++; $display("FAIL wr_rd_twtr: got %0d want 4", ec(2) - ec(1));
    end
    n_checks++;
    if (ei(2) !== mk(C_RD, 2, 8'h33)) begin
      n_fail++; $display("FAIL wtr_rd_instr: got %h want %h", ei(2), mk(C_RD, 2, 8'h33));
    end
  endtask

  task automatic test_illegal();
    int a, p;
    do_reset();
    send(mk(C_RD, 3, 8'h41), a);
    repeat (6) @(negedge clk);
    n_checks++;
    if (ev_cyc.size() !== 0) begin
      n_fail++; $display("FAIL rd_closed_dec_en: got %0d pulses want 0", ev_cyc.size());
    end
    n_checks++;
    if (pe_cyc.size() !== 1) begin
      n_fail++; $display("FAIL rd_closed_proto_cnt: got %0d want 1", pe_cyc.size());
    end
    p = (pe_cyc.size() > 0) ? pe_cyc[0] - a : -1;
    n_checks++;
    if (p !== 2) begin
      n_fail++; $display("FAIL rd_closed_proto_lat: got %0d want 2", p);
    end
    n_checks++;
    if (pe_rdy.size() == 0 || pe_rdy[0] !== 1'b1) begin
      n_fail++; $display("FAIL rd_closed_ready_after: in_ready not high after drop (pulses %0d)", pe_rdy.size());
    end
    send(mk(C_ACT, 0, 8'h42), a);
    send(mk(C_REF, 0, 8'h43), a);
    repeat (8) @(negedge clk);
    n_checks++;
    if (ev_cyc.size() !== 1) begin
      n_fail++; $display("FAIL ref_open_dec_en: got %0d pulses want 1", ev_cyc.size());
    end
    n_checks++;
    if (pe_cyc.size() !== 2) begin
      n_fail++; $display("FAIL ref_open_proto_cnt: got %0d want 2", pe_cyc.size());
    end
    n_checks++;
    if (bus.bank_open !== 8'h01) begin
      n_fail++; $display("FAIL ref_open_bank_open: got %h want 01", bus.bank_open);
    end
  endtask

  task automatic test_ref_nop();
    int a;
    do_reset();
    send(mk(C_REF, 0, 8'h50), a);
    for (int i = 1; i <= 5; i++) send(mk(C_NOP, 0, 8'h50 + 8'(i)), a);
    send(mk(C_ACT, 0, 8'h56), a);
    wait_ev(7, 80);
    for (int i = 1; i <= 5; i++) begin
      n_checks++;
      if (ec(i) - ec(i - 1) !== 1) begin
        n_fail++; $display("FAIL nop_stream_%0d: spacing %0d want 1", i, ec(i) - ec(i - 1));
      end
    end
    n_checks++;
    if (ec(6) - ec(0) !== 30) begin
      n_fail++; $display("FAIL ref_act_trfc: got %0d want 30", ec(6) - ec(0));
    end
    n_checks++;
    if (ei(6) !== mk(C_ACT, 0, 8'h56)) begin
      n_fail++; $display("FAIL ref_act_instr: got %h want %h", ei(6), mk(C_ACT, 0, 8'h56));
    end
  endtask

  task automatic test_pre_closed();
    int a;
    logic [7:0] b1;
    do_reset();
    send(mk(C_PRE, 5, 8'h61), a);
    send(mk(C_ACT, 5, 8'h62), a);
    wait_ev(2, 40);
    n_checks++;
    if (pe_cyc.size() !== 0) begin
      n_fail++; $display("FAIL pre_closed_proto: got %0d pulses want 0", pe_cyc.size());
    end
    n_checks++;
    if (ec(1) - ec(0) !== 4) begin
      n_fail++; $display("FAIL pre_closed_trp: got %0d want 4", ec(1) - ec(0));
    end
    b1 = ebo(1);
    n_checks++;
    if (b1[5] !== 1'b1) begin
      n_fail++; $display("FAIL pre_closed_act_open: got %b want 1", b1[5]);
    end
  endtask

`ifdef CMD_SCHED_STATS_EN
  task automatic test_stats();
    int a;
    do_reset();
    n_checks++;
    if (stall_cycles !== 32'd0) begin
      n_fail++; $display("FAIL stats_reset: got %0d want 0", stall_cycles);
    end
    send(mk(C_ACT, 0, 8'h71), a);
    @(negedge clk);
    send(mk(C_PRE, 0, 8'h72), a);
    wait_ev(2, 40);
    n_checks++;
    if (stall_cycles !== 32'd8) begin
      n_fail++; $display("FAIL stats_stall8: got %0d want 8", stall_cycles);
    end
  endtask
`endif

  task automatic test_reset_mid_hold();
    int a, n_before;
    do_reset();
    send(mk(C_ACT, 0, 8'h81), a);
    send(mk(C_PRE, 0, 8'h82), a);
    send(mk(C_ACT, 0, 8'h83), a);
    wait_ev(2, 60);
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    n_checks++;
    if (bus.bank_open !== 8'h00) begin
      n_fail++; $display("FAIL midhold_bank_open: got %h want 00", bus.bank_open);
    end
    n_checks++;
    if (bus.in_ready !== 1'b1) begin
      n_fail++; $display("FAIL midhold_in_ready: got %b want 1", bus.in_ready);
    end
`ifdef CMD_SCHED_STATS_EN
    n_checks++;
    if (stall_cycles !== 32'd0) begin
      n_fail++; $display("FAIL midhold_stats: got %0d want 0", stall_cycles);
    end
`endif
    rst_n = 1'b1;
    n_before = ev_cyc.size();
    repeat (12) @(negedge clk);
    n_checks++;
    if (ev_cyc.size() !== n_before) begin
      n_fail++; $display("FAIL midhold_dropped: got %0d pulses want %0d", ev_cyc.size(), n_before);
    end
    send(mk(C_ACT, 0, 8'h84), a);
    wait_ev(n_before + 1, 20);
    n_checks++;
    if (ec(n_before) - a !== 2) begin
      n_fail++; $display("FAIL midhold_act_latency: got %0d want 2", ec(n_before) - a);
    end
    n_checks++;
    if (ei(n_before) !== mk(C_ACT, 0, 8'h84)) begin
      n_fail++; $display("FAIL midhold_act_instr: got %h want %h", ei(n_before), mk(C_ACT, 0, 8'h84));
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.in_valid = 1'b0;
    bus.in_instr = '0;
    @(negedge clk);
    test_reset();
    test_act_rd();
    test_act_pre_act();
    test_wtr();
    test_illegal();
    test_ref_nop();
    test_pre_closed();
`ifdef CMD_SCHED_STATS_EN
    test_stats();
`endif
    test_reset_mid_hold();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/cmd_timing_scheduler.md
Name: cmd_timing_scheduler

Overview:
- Sits between the host instruction FIFO and the instruction decoder.
- Takes 32-bit SoftMC instructions over a valid/ready handshake and tracks per-bank open/closed state and DDR4 timing counters.
- Releases each instruction to the decoder as a single-cycle enable only once every applicable timing constraint is met.
- Rejects protocol-illegal commands and flags them.

Parameters:
- BANK_WIDTH, 3, bank address bits; 2**BANK_WIDTH banks tracked.
- CNT_WIDTH, 8, width of every timing counter.
- T_RCD, 4, min cycles ACT -> RD/WR, same bank.
- T_RP, 4, min cycles PRE -> ACT, same bank.
- T_RAS, 10, min cycles ACT -> PRE, same bank.
- T_RRD, 2, min cycles ACT -> ACT, any bank.
- T_CCD, 2, min cycles RD/WR -> RD/WR, any bank.
- T_WTR, 4, min cycles WR -> RD, any bank.
- T_RFC, 30, min cycles REF -> any non-NOP command.

Ports:
- clk  in  1  controller clock.
- rst_n  in  1  synchronous active-low reset.
- in_valid  in  1  instruction available.
- in_instr  in  32  SoftMC instruction; fields located by softMC.inc offset macros.
- in_ready  out  1  scheduler accepts in_instr this cycle.
- dec_en  out  1  one-cycle enable to decoder.
- dec_instr  out  32  instruction presented with dec_en.
- bank_open  out  2**BANK_WIDTH  per-bank row-open status.
- proto_err  out  1  one-cycle pulse: illegal command dropped.
- stall_cycles  out  32  present only with the optional feature.

Behaviour:
- Decode (CS low, RAS/CAS/WE): LHH=ACT, HLH=RD, HLL=WR, LHL=PRE, LLH=REF, HHH=NOP. CS high = DESEL.
- Bank index is in_instr[`ROW_OFFSET +: BANK_WIDTH].
- Single holding register (hold_valid, hold_instr).
  - in_ready = !hold_valid || issue_now.
  - Accept when in_valid && in_ready.
- issue_now is asserted when hold_valid and every applicable counter is 0.
  - dec_en and dec_instr are registered and appear the cycle after issue_now.
  - Minimum latency from accept to dec_en is 2 cycles. Back-to-back NOPs sustain one dec_en per cycle.
- Counters are saturating down-counters, decremented each cycle while nonzero.
  - On issue of command X, load T-1 into each counter gating later commands on X.
  - Result: consecutive dec_en pulses are spaced at least T cycles apart.
- Per-bank counters:
  - ACT loads rcd[b]=T_RCD-1 and ras[b]=T_RAS-1.
  - PRE loads rp[b]=T_RP-1.
- Global counters:
  - ACT loads rrd=T_RRD-1.
  - RD/WR load ccd=T_CCD-1.
  - WR loads wtr=T_WTR-1.
  - REF loads rfc=T_RFC-1.
- Gating:
  - ACT waits on rp[b], rrd, rfc.
  - RD waits on rcd[b], ccd, wtr, rfc.
  - WR waits on rcd[b], ccd, rfc.
  - PRE waits on ras[b], rfc.
  - REF waits on rp[all], rfc.
  - NOP/DESEL are never gated.
- bank_open[b]: set on ACT issue, cleared on PRE issue.
- Illegal commands are dropped at the issue decision (no dec_en), proto_err pulses for 1 cycle, and the holding register is freed:
  - ACT to an open bank.
  - RD/WR to a closed bank.
  - REF with any bank open.
- PRE to a closed bank is legal: issued, no state change, rp[b] still loaded.
- State machine: IDLE (no hold) -> HOLD (waiting on counters) -> IDLE on issue or drop. HOLD -> HOLD when a new instruction is accepted in the same cycle as issue.
- Reset (any time, including mid-hold):
  - Drops the held instruction.
  - All counters = 0, bank_open = 0.
  - dec_en = 0, dec_instr = 0, proto_err = 0, in_ready = 1, stall_cycles = 0.

Optional Feature:
- Macro: CMD_SCHED_STATS_EN.
- Defined: stall_cycles port exists. It increments by 1 each cycle with hold_valid && !issue_now, saturating at 2**32-1, and is cleared by reset.
- Undefined: the port and counter are absent; all other behaviour is identical.

Decomposition:
- Shared package/include holds:
  - The command-class encoding constants (ACT/RD/WR/PRE/REF/NOP/DESEL).
  - A function decoding the class from the RAS/CAS/WE/CS bits.
  - Default timing values.
- One natural sub-module: sched_down_counter, a loadable saturating down-counter with a zero flag, instantiated per bank and globally.

Test Plan:
- ACT b0 then RD b0 presented immediately -> RD dec_en exactly 4 cycles after ACT dec_en; bank_open[0]=1 after ACT.
- ACT b1, then PRE b1 at once -> PRE delayed to ACT+10; following ACT b1 at PRE+4; bank_open[1] toggles 1 -> 0 -> 1.
- WR b2 then RD b2 (bank open) -> RD issued at WR+4 (tWTR dominates tCCD=2).
- RD to closed b3 -> no dec_en, proto_err one pulse, in_ready high next cycle; REF with b0 open -> same.
- REF with all banks closed, then ACT b0 -> ACT dec_en at REF+30; NOP stream in between issues every cycle.
- rst_n low while ACT is held on rp -> held instruction lost, bank_open=0, counters 0; ACT after reset issues at minimum latency. With CMD_SCHED_STATS_EN, stall_cycles reads 0 after reset and 8 after a fully stalled 8-cycle hold.
